// File: rtl/la_capture_ctrl.sv
// rtl/la_capture_ctrl.sv - logic-analyser capture controller (pre-fill, pattern trigger, post-count)
// Optional macro TRIG_EDGE_EN adds trig_edge_i for rising-into-match trigger qualification.

module la_capture_ctrl #(
    parameter int CH = 8,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          sample_clk_en_i,
    input  logic [CH-1:0] probe_i,
    input  logic          arm_i,
    input  logic          abort_i,
    input  logic [AW-1:0] pre_count_i,
    input  logic [AW-1:0] post_count_i,
    input  logic [CH-1:0] trig_mask_i,
    input  logic [CH-1:0] trig_value_i,
`ifdef TRIG_EDGE_EN
    input  logic          trig_edge_i,
`endif
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [CH-1:0] mem_wdata_o,
    output logic [AW-1:0] trig_addr_o,
    output logic [AW-1:0] start_addr_o,
    output logic          busy_o,
    output logic          triggered_o,
    output logic          done_o
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CH-1:0] probe_meta_q, probe_s_q;
    logic [AW-1:0] wr_ptr_q, pre_cnt_q, post_cnt_q, pre_len_q, post_len_q;
    logic [CH-1:0] mask_q, value_q;
    logic          mem_we_q, triggered_q;
    logic [AW-1:0] mem_addr_q, trig_addr_q, start_addr_q;
    logic [CH-1:0] mem_wdata_q;
    logic          wr_en, arm_go, match, trig_hit, overwrite;
    logic [AW:0]   span;
    logic [AW-1:0] final_trig_addr;

    assign wr_en    = busy_o & sample_clk_en_i & ~abort_i;
    assign arm_go   = arm_i & ~abort_i & ~busy_o;
    assign match    = ((probe_s_q ^ value_q) & mask_q) == '0;
    assign span     = {1'b0, pre_len_q} + {1'b0, post_len_q};
    assign overwrite = span > (AW+1)'(DEPTH);
    assign final_trig_addr = (state_q == S_WAIT) ? wr_ptr_q : trig_addr_q;

`ifdef TRIG_EDGE_EN
    logic edge_q, prev_valid_q, prev_match_q;

    // prev_* describe the most recently stored sample of this capture
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            edge_q       <= 1'b0;
            prev_valid_q <= 1'b0;
            prev_match_q <= 1'b0;
        end else if (arm_go) begin
            edge_q       <= trig_edge_i;
            prev_valid_q <= 1'b0;
            prev_match_q <= 1'b0;
        end else if (wr_en) begin
            prev_valid_q <= 1'b1;
            prev_match_q <= match;
        end
    end

    assign trig_hit = match & (~edge_q | (prev_valid_q & ~prev_match_q));
`else
    assign trig_hit = match;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE:
                    if (arm_i) state_d = (pre_count_i == '0) ? S_WAIT : S_PRE;
                S_PRE:
                    if (sample_clk_en_i && (pre_cnt_q + AW'(1) == pre_len_q)) state_d = S_WAIT;
                S_WAIT:
                    if (sample_clk_en_i && trig_hit)
                        state_d = (post_len_q == AW'(1)) ? S_DONE : S_POST;
                S_POST:
                    if (sample_clk_en_i && (post_cnt_q + AW'(1) == post_len_q)) state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_q)
            S_PRE, S_WAIT, S_POST: busy_o = 1'b1;
            S_DONE:                done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            probe_meta_q <= '0;
            probe_s_q    <= '0;
        end else begin
            probe_meta_q <= probe_i;
            probe_s_q    <= probe_meta_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            pre_len_q    <= '0;
            post_len_q   <= '0;
            mask_q       <= '0;
            value_q      <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            triggered_q  <= 1'b0;
        end else begin
            mem_we_q <= wr_en;
            if (wr_en) begin
                mem_addr_q  <= wr_ptr_q;
                mem_wdata_q <= probe_s_q;
                wr_ptr_q    <= wr_ptr_q + AW'(1);
                if (state_q == S_PRE)  pre_cnt_q  <= pre_cnt_q + AW'(1);
                if (state_q == S_POST) post_cnt_q <= post_cnt_q + AW'(1);
                if (state_q == S_WAIT && trig_hit) begin
                    trig_addr_q <= wr_ptr_q;
                    triggered_q <= 1'b1;
                    post_cnt_q  <= AW'(1);
                end
            end
            if (state_d == S_DONE && state_q != S_DONE)
                start_addr_q <= overwrite ? wr_ptr_q + AW'(1) : final_trig_addr - pre_len_q;
            // pre_count_i is AW bits wide, so it can never exceed DEPTH-1
            if (arm_go) begin
                wr_ptr_q    <= '0;
                pre_cnt_q   <= '0;
                post_cnt_q  <= '0;
                triggered_q <= 1'b0;
                pre_len_q   <= pre_count_i;
                post_len_q  <= (post_count_i == '0) ? AW'(1) : post_count_i;
                mask_q      <= trig_mask_i;
                value_q     <= trig_value_i;
            end
            if (abort_i) triggered_q <= 1'b0;
        end
    end

    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign trig_addr_o  = trig_addr_q;
    assign start_addr_o = start_addr_q;
    assign triggered_o  = triggered_q;

endmodule

// File: doc/la_capture_ctrl.md
Name: la_capture_ctrl

Overview:
- Consumer of the `sample_clk_en` strobe from the sample-rate divider.
- On each strobe it samples the probe bus and writes the sample into a circular capture RAM.
- Implements a pre-trigger fill, a mask/value pattern trigger and a post-trigger count.
- Reports the trigger address and the address of the oldest valid sample, so the readout path can linearise the buffer.

Parameters:
- CH, 8, probe channel count (sample width).
- AW, 12, capture RAM address width; DEPTH = 2^AW.

Ports:
- clk  in  1  system clock (27 MHz).
- resetn  in  1  reset.
- sample_clk_en  in  1  one-cycle sample strobe from the divider.
- probe  in  CH  raw asynchronous probe inputs.
- arm  in  1  one-cycle pulse; starts a capture.
- abort  in  1  one-cycle pulse; cancels a capture.
- pre_count  in  AW  samples to store before the trigger is allowed.
- post_count  in  AW  samples to store from the trigger sample onward.
- trig_mask  in  CH  1 = channel participates in the trigger.
- trig_value  in  CH  required level on masked channels.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM write address.
- mem_wdata  out  CH  RAM write data.
- trig_addr  out  AW  address of the trigger sample.
- start_addr  out  AW  address of the oldest valid sample.
- busy  out  1  high in PRE, WAIT_TRIG and POST.
- triggered  out  1  trigger seen in the current capture.
- done  out  1  capture complete.

Behaviour:
- Reset and clock: reset resetn, asynchronous, active-low; clock clk.
- Reset values: all outputs 0; state IDLE; write pointer 0.
- Probe synchroniser: probe passes through a 2-flop synchroniser giving probe_s.
  - Only probe_s is sampled.
  - Input-to-sample latency is 2 clk.
- Write timing: if sample_clk_en = 1 in cycle N while in PRE, WAIT_TRIG or POST:
  - cycle N+1: mem_we = 1, mem_addr = wr_ptr, mem_wdata = probe_s as of cycle N.
  - wr_ptr then increments mod DEPTH; it wraps silently.
  - In every other case mem_we = 0.
- Latched values: trigger match for a sample = ((sample ^ trig_value) & trig_mask) == 0. pre_count, post_count, trig_mask and trig_value are latched on arm and ignored afterwards.
- Zero values: trig_mask = 0 matches the first eligible sample. post_count = 0 is treated as 1.
- pre_count clamp: if pre_count > DEPTH-1, the latched value is DEPTH-1.
- State IDLE:
  - arm → PRE. wr_ptr, pre_cnt, post_cnt, triggered and done all clear.
  - If latched pre_count = 0, arm → WAIT_TRIG directly.
- State PRE:
  - Each written sample increments pre_cnt.
  - The trigger is not evaluated.
  - On the write that makes pre_cnt = pre_count → WAIT_TRIG.
- State WAIT_TRIG: every strobe writes a sample. The first sample that matches:
  - is written;
  - sets trig_addr = its address and triggered = 1;
  - sets post_cnt = 1;
  - goes → POST, or → DONE if post_count = 1.
- State POST:
  - Each write increments post_cnt.
  - On the write where post_cnt reaches post_count → DONE.
- State DONE: done = 1, busy = 0.
  - start_addr = (trig_addr − pre_count) mod DEPTH.
  - If pre_count + post_count > DEPTH, start_addr = final wr_ptr, because the oldest pre-samples were overwritten.
  - Outputs hold until the next arm or abort.
- abort, in any state: → IDLE next cycle. done = 0, triggered = 0, no further mem_we. trig_addr and start_addr keep their last values.
- Simultaneous events:
  - arm and abort in the same cycle: abort wins.
  - arm while busy: ignored.
  - arm in DONE: re-arms exactly as from IDLE.
  - sample_clk_en in the arm cycle: ignored; sampling begins on the next strobe.
- Reset mid-capture: immediate return to reset values; a partial buffer is not flagged.

Optional Feature:
- Macro TRIG_EDGE_EN adds input port `trig_edge` (1 bit), latched on arm.
- With TRIG_EDGE_EN and trig_edge = 1:
  - A sample matches only if it satisfies the pattern and the previous stored sample did not.
  - The first sample in WAIT_TRIG compares against the last PRE sample; if there was none (pre_count = 0), it cannot trigger.
- With trig_edge = 0, or without the macro: level match only, and the port is absent.

Test Plan:
All scenarios use AW=4 (DEPTH 16) and CH=8.
1. Immediate trigger: strobe every cycle, pre=0, post=5, mask=0x00, arm → 5 writes to addresses 0..4, trig_addr=0, start_addr=0, done=1 after the 5th mem_we.
2. Pre/post capture: pre=3, post=4, mask=0x01, value=0x01; probe bit0 rises before the 6th strobe → addresses 0..2 pre-fill; trigger write at the first matching address; trig_addr=5, start_addr=2, done after address 8.
3. Wrap-around: pre=10, post=10, trigger at the 14th sample → writes wrap past 15 to 0; start_addr = final wr_ptr; each address 0..15 written at least once.
4. Abort mid-POST: abort asserted after 2 post writes → state IDLE next cycle, mem_we stays 0 on later strobes, done=0, triggered=0.
5. Divider strobe every 270 cycles: post=2 → exactly one mem_we per strobe, and mem_we fires one cycle after each sample_clk_en.
6. (TRIG_EDGE_EN) Edge trigger: trig_edge=1, mask=0x80, probe bit7 held high from arm, pre=1 → no trigger until bit7 falls, then rises; trig_addr = address of the rising sample.
